shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Parametrised sequential multiplier, the successor to the fixed 4x4 combinational array multiplier. It computes a WIDTH x WIDTH product over WIDTH/BITS_PER_CYCLE clock cycles, each cycle retiring BITS_PER_CYCLE multiplier bits. Per operation it selects unsigned or two's-complement signed mode. It sits behind valid/ready handshakes, so it can be placed between a register-mapped operand source and a result consumer that may stall.

## Interface
Parameters:
- WIDTH, default 4: operand width in bits; must be 2 or more.
- BITS_PER_CYCLE, default 1: multiplier bits retired per cycle; must divide WIDTH.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  out_p holds a finished product.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2*WIDTH  product.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- IDLE:
  - in_ready = 1.
  - in_valid & in_ready loads the registers: in_a sign- or zero-extended to 2*WIDTH per in_signed, in_b, in_signed, accumulator = 0, step counter = 0.
  - State goes to RUN.
- RUN: in_ready = 0. On each edge:
  - Add (multiplicand x next BITS_PER_CYCLE bits of multiplier, LSB group first) shifted to its bit position into the accumulator.
  - Increment the counter.
  - After step NSTEPS = WIDTH/BITS_PER_CYCLE, go to DONE.
- Signed mode: the MSB of in_b carries weight -2^(WIDTH-1), so its partial product is subtracted rather than added. Unsigned mode adds all groups.
- Arithmetic is modulo 2^(2*WIDTH). The result is exact in both modes, including -2^(WIDTH-1) x -2^(WIDTH-1).
- DONE:
  - out_valid = 1 and out_p = accumulator, held stable until out_valid & out_ready.
  - On that edge, go to IDLE.
- out_p is driven from the accumulator register and is 0 in IDLE.
- in_valid during RUN or DONE is ignored. Operands are sampled only on the accept edge; later changes have no effect.
- in_signed is latched per operation, so mixed-mode back-to-back operations are legal.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_p = 0, state IDLE, counter 0.
- Latency: operands accepted at edge k put out_valid high after edge k+NSTEPS.
- With out_ready held high:
  - IDLE is re-entered at edge k+NSTEPS+1.
  - The next accept is at the earliest edge k+NSTEPS+2.
  - Throughput is one product per NSTEPS+2 cycles.
- Back-pressure: DONE is held indefinitely while out_ready = 0. No result is lost or overwritten.
- out_ready while not in DONE has no effect.
- Reset asserted in any state, including mid-RUN, immediately clears all outputs to their reset values. The operation in flight is discarded. No out_valid is produced for it after reset releases.
- There is no combinational path from in_* to out_* or from out_ready to in_ready.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing NSTEPS;
  - elaboration-time checks (WIDTH >= 2, WIDTH % BITS_PER_CYCLE == 0).
- Sub-module mult_step is combinational. Inputs: multiplicand, BITS_PER_CYCLE multiplier bits, step index, signed flag, accumulator. Output: next accumulator, with the MSB-group subtraction inside.
- The top level owns the FSM, the counter and the registers, and instantiates one mult_step.

## Test plan
- WIDTH=4, BITS_PER_CYCLE=1, unsigned:
  - 15 x 15 -> out_p = 0xE1, out_valid exactly 4 edges after accept.
  - 0 x 9 -> 0x00.
- WIDTH=4, signed:
  - -8 x -8 -> 0x40.
  - -8 x 7 -> 0xC8.
  - 5 x -3 -> 0xF1.
- WIDTH=8, BITS_PER_CYCLE=2:
  - unsigned 200 x 3 -> 0x0258 after 4 steps.
  - signed -128 x -1 -> 0x0080.
- Back-pressure: hold out_ready = 0 for 10 cycles in DONE.
  - out_p stays stable, in_ready stays 0, a pending in_valid is not accepted.
  - Release out_ready -> IDLE next edge, new accept the edge after.
- Reset mid-RUN (step 2 of 4):
  - Outputs return to their reset values at once.
  - After release, a new op 3 x 4 -> 0x0C completes normally.
- Exhaustive: WIDTH=4, all 256 operand pairs in both modes, back-to-back with out_ready = 1.
  - Every product matches the golden model.
  - Accepts occur every NSTEPS+2 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM encoding, step-count helper and configuration check.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nsteps(int width, int bpc);
    return width / bpc;
  endfunction

  function automatic bit cfg_ok(int width, int bpc);
    return (width >= 2) && (bpc >= 1) && (width % bpc == 0);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: folds a group of multiplier bits into the
// accumulator; in signed mode the multiplier MSB carries negative weight.
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int BITS_PER_CYCLE = 1,
  parameter int CW             = 3
) (
  input  logic [2*WIDTH-1:0]        mcand,
  input  logic [BITS_PER_CYCLE-1:0] bits,
  input  logic [CW-1:0]             step,
  input  logic                      is_signed,
  input  logic [2*WIDTH-1:0]        acc,
  output logic [2*WIDTH-1:0]        acc_nxt
);

  localparam int NSTEPS = nsteps(WIDTH, BITS_PER_CYCLE);
  localparam int PW     = 2 * WIDTH;

  logic          last;
  logic [31:0]   base;
  logic [PW-1:0] pp;

  assign last = (32'(step) == 32'(NSTEPS - 1));

  always_comb begin
    acc_nxt = acc;
    pp      = '0;
    base    = 32'(step) * 32'(BITS_PER_CYCLE);
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      pp = bits[j] ? (mcand << (base + 32'(j))) : '0;
      // Two's-complement MSB weighs -2^(WIDTH-1)
      if (is_signed && last && (j == BITS_PER_CYCLE - 1))
        acc_nxt = acc_nxt - pp;
      else
        acc_nxt = acc_nxt + pp;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier behind valid/ready handshakes,
// retiring BITS_PER_CYCLE multiplier bits per clock.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int NSTEPS = nsteps(WIDTH, BITS_PER_CYCLE);
  localparam int CW     = $clog2(NSTEPS + 1);
  localparam int PW     = 2 * WIDTH;

  if (!cfg_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
    $error("shift_add_multiplier: illegal WIDTH/BITS_PER_CYCLE");
  end

  state_e           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nxt;
  logic [WIDTH-1:0] mplier;
  logic             sgn;
  logic [CW-1:0]    cnt;
  logic             last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_p     = acc;
  assign last_step = (cnt == CW'(NSTEPS - 1));

  mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CW             (CW)
  ) u_step (
    .mcand     (mcand),
    .bits      (mplier[BITS_PER_CYCLE-1:0]),
    .step      (cnt),
    .is_signed (sgn),
    .acc       (acc),
    .acc_nxt   (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      sgn    <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state  <= RUN;
            mcand  <= in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a}
                                : {{WIDTH{1'b0}}, in_a};
            mplier <= in_b;
            sgn    <= in_signed;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          // Low group of mplier is always the next one to retire
          acc    <= acc_nxt;
          mplier <= mplier >> BITS_PER_CYCLE;
          cnt    <= cnt + 1'b1;
          if (last_step)
            state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            acc   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: W4/B1 and W8/B2 instances checked
// every cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_shift_add_multiplier;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] iv;
  logic [1:0] isg;
  logic [1:0] ordy;
  logic [7:0] ia [2];
  logic [7:0] ib [2];
  wire  [1:0] irdy;
  wire  [1:0] ov;
  wire  [7:0] p4;
  wire [15:0] p8;
  logic [15:0] op [2];

  assign op[0] = {8'h00, p4};
  assign op[1] = p8;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[0]),
    .in_ready  (irdy[0]),
    .in_a      (ia[0][3:0]),
    .in_b      (ib[0][3:0]),
    .in_signed (isg[0]),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .out_p     (p4)
  );

  shift_add_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv[1]),
    .in_ready  (irdy[1]),
    .in_a      (ia[1]),
    .in_b      (ib[1]),
    .in_signed (isg[1]),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .out_p     (p8)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] gold(int w, logic [7:0] a,
                                       logic [7:0] b, bit s);
    longint x, y, m;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    return 16'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Reference model: one op in flight per instance, result after N edges
  int          cyc = 0;
  bit          busy [2];
  int          acc_cyc [2];
  logic [15:0] exp_p [2];

  initial begin
    busy[0] = 0;
    busy[1] = 0;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        busy[0] = 0;
        busy[1] = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          bit was, vx;
          was = busy[d];
          vx  = was && (cyc - acc_cyc[d] >= N);
          if (vx && ordy[d]) busy[d] = 0;
          if (!was && iv[d]) begin
            busy[d]    = 1;
            acc_cyc[d] = cyc + 1;
            exp_p[d]   = gold(d == 0 ? 4 : 8, ia[d], ib[d], isg[d]);
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bit vx;
        vx = busy[d] && (cyc - acc_cyc[d] >= N);
        chk($sformatf("in_ready[%0d]", d), 16'(irdy[d]), 16'(!busy[d]));
        chk($sformatf("out_valid[%0d]", d), 16'(ov[d]), 16'(vx));
        if (vx)
          chk($sformatf("out_p[%0d]", d), op[d], exp_p[d]);
        else if (!busy[d])
          chk($sformatf("out_p_idle[%0d]", d), op[d], 16'h0);
      end
    end
  end

  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b,
                       input bit s, output logic [15:0] p, output int lat);
    int t;
    t = 0;
    while (!irdy[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!irdy[d]) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout[%0d]: in_ready stuck low", d);
    end
    iv[d] = 1'b1;
    ia[d] = a;
    ib[d] = b;
    isg[d] = s;
    @(negedge clk);
    iv[d] = 1'b0;
    ia[d] = 8'($urandom);
    ib[d] = 8'($urandom);
    isg[d] = 1'($urandom);
    lat = 0;
    while (!ov[d] && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    p = op[d];
    if (!ov[d]) begin
      n_chk++;
      n_fail++;
      $display("FAIL result_timeout[%0d]: out_valid never rose", d);
    end
  endtask

  logic [15:0] p;
  int          lat;
  int          t;
  int          last_acc;

  initial begin
    rst_n = 1'b0;
    iv = 2'b00;
    isg = 2'b00;
    ordy = 2'b11;
    ia[0] = 8'h0; ia[1] = 8'h0;
    ib[0] = 8'h0; ib[1] = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 16'(irdy), 16'h3);
    chk("rst out_valid", 16'(ov), 16'h0);
    chk("rst out_p4", 16'(p4), 16'h0);
    chk("rst out_p8", p8, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    chk("gold 15x15", gold(4, 8'd15, 8'd15, 0), 16'h00E1);
    chk("gold -8x-8", gold(4, 8'h8, 8'h8, 1), 16'h0040);
    chk("gold 200x3", gold(8, 8'd200, 8'd3, 0), 16'h0258);
    chk("gold -128x-1", gold(8, 8'h80, 8'hFF, 1), 16'h0080);

    do_op(0, 8'd15, 8'd15, 0, p, lat);
    chk("15x15", p, 16'h00E1);
    chk("15x15 latency", 16'(lat), 16'd4);
    do_op(0, 8'd0, 8'd9, 0, p, lat);
    chk("0x9", p, 16'h0000);
    do_op(0, 8'h8, 8'h8, 1, p, lat);
    chk("-8x-8", p, 16'h0040);
    do_op(0, 8'h8, 8'h7, 1, p, lat);
    chk("-8x7", p, 16'h00C8);
    do_op(0, 8'h5, 8'hD, 1, p, lat);
    chk("5x-3", p, 16'h00F1);
    do_op(1, 8'd200, 8'd3, 0, p, lat);
    chk("200x3", p, 16'h0258);
    chk("200x3 latency", 16'(lat), 16'd4);
    do_op(1, 8'h80, 8'hFF, 1, p, lat);
    chk("-128x-1", p, 16'h0080);

    // Back-pressure with a pending request
    ordy[0] = 1'b0;
    do_op(0, 8'd11, 8'd6, 0, p, lat);
    chk("bp result", p, 16'd66);
    iv[0] = 1'b1;
    ia[0] = 8'd3;
    ib[0] = 8'd3;
    isg[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp out_p hold", op[0], 16'd66);
      chk("bp in_ready", 16'(irdy[0]), 16'h0);
      chk("bp out_valid", 16'(ov[0]), 16'h1);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp release idle", 16'(irdy[0]), 16'h1);
    chk("bp release valid", 16'(ov[0]), 16'h0);
    @(negedge clk);
    chk("bp reaccept", 16'(irdy[0]), 16'h0);
    iv[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Reset after two of four steps
    iv[0] = 1'b1;
    ia[0] = 8'd9;
    ib[0] = 8'd7;
    isg[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid-run busy", 16'(irdy[0]), 16'h0);
    rst_n = 1'b0;
    #1;
    chk("rst mid in_ready", 16'(irdy[0]), 16'h1);
    chk("rst mid out_valid", 16'(ov[0]), 16'h0);
    chk("rst mid out_p", 16'(p4), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 8'd3, 8'd4, 0, p, lat);
    chk("3x4 after reset", p, 16'h000C);
    chk("3x4 latency", 16'(lat), 16'd4);

    // Exhaustive back-to-back on the 4-bit instance
    last_acc = -1;
    iv[0] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          t = 0;
          while (!irdy[0] && t < 20) begin
            @(negedge clk);
            t++;
          end
          ia[0] = 8'(a);
          ib[0] = 8'(b);
          isg[0] = 1'(s);
          iv[0] = 1'b1;
          @(negedge clk);
          if (last_acc >= 0)
            chk("accept spacing", 16'(cyc - last_acc), 16'(N + 2));
          last_acc = cyc;
        end
      end
    end
    iv[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Random traffic with random stalls on both instances
    fork
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        iv[0] = 1'($urandom);
        ia[0] = 8'($urandom);
        ib[0] = 8'($urandom);
        isg[0] = 1'($urandom);
        ordy[0] = ($urandom_range(3) != 0);
      end
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        iv[1] = 1'($urandom);
        ia[1] = 8'($urandom);
        ib[1] = 8'($urandom);
        isg[1] = 1'($urandom);
        ordy[1] = ($urandom_range(3) != 0);
      end
    join
    iv = 2'b00;
    ordy = 2'b11;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
